// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants, FSM state type and sample-fitting helpers
//               for the inverse moving-sum FIR (fir_inverse).
//               NUM_TAPS - moving-sum window length (history depth)
//               SAMPLE_W - recovered sample width (FIR input width)
//               SUM_W    - incoming sum width (FIR output width)
//               DIFF_W   - width of the reconstruction arithmetic
// Macro       : FIR_INV_SAT_EN - when defined, out-of-range results are
//               clamped; otherwise they wrap to the low SAMPLE_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int NUM_TAPS = 5;
  localparam int SAMPLE_W = 4;
  localparam int SUM_W    = 16;
  // Two guard bits cover In - y_prev + hist without overflow.
  localparam int DIFF_W   = SUM_W + 2;

  localparam logic signed [DIFF_W-1:0] C_SAMPLE_MAX = DIFF_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] C_SAMPLE_MIN = DIFF_W'(-(2 ** (SAMPLE_W - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // True when d is representable as a SAMPLE_W-bit signed sample.
  function automatic logic sample_in_range(input logic signed [DIFF_W-1:0] d);
    return (d >= C_SAMPLE_MIN) && (d <= C_SAMPLE_MAX);
  endfunction

  // Reduce a reconstruction result to sample width.
  function automatic logic signed [SAMPLE_W-1:0] fit_sample(input logic signed [DIFF_W-1:0] d);
`ifdef FIR_INV_SAT_EN
    if (d > C_SAMPLE_MAX) begin
      return C_SAMPLE_MAX[SAMPLE_W-1:0];
    end else if (d < C_SAMPLE_MIN) begin
      return C_SAMPLE_MIN[SAMPLE_W-1:0];
    end else begin
      return d[SAMPLE_W-1:0];
    end
`else
    return d[SAMPLE_W-1:0];
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_inv_hist.sv
// ============================================================================
// Module      : fir_inv_hist
// Description : DEPTH x WIDTH shift register holding the most recent
//               recovered samples; newest at the head, oldest at the tail.
// Ports       : clk      - clock, posedge
//               rst_n    - synchronous active-low reset (clears all entries)
//               shift_en - shift din in at the head
//               din      - new sample
//               tail     - oldest stored sample (DEPTH shifts ago)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_inv_hist #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tail
);

  logic [WIDTH-1:0] r_taps [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_taps[i] <= '0;
      end
    end else if (shift_en) begin
      r_taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
    end
  end

  assign tail = r_taps[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fir_inverse.sv
// ============================================================================
// Module      : fir_inverse
// Description : Recovers x[n] from the 5-tap unit-coefficient moving sum
//               y[n] using x[n] = y[n] - y[n-1] + x[n-5], with valid/ready
//               handshakes and a one-cycle registered output.
// Ports       : clk        - clock, posedge
//               rst_n      - synchronous active-low reset
//               in_valid   - In carries a valid sum sample
//               in_ready   - block accepts In this cycle
//               In         - signed sum sample y[n]
//               out_valid  - Out holds a valid recovered sample
//               out_ready  - downstream consumes Out this cycle
//               Out        - signed recovered sample x[n]
//               clr_err    - clear range_err, return ERR -> RUN
//               range_err  - sticky out-of-range flag
//               sample_cnt - accepted sample count (wraps)
// Macro       : FIR_INV_SAT_EN - clamp out-of-range results instead of wrap.
//               The fitting helper uses fir_pkg widths, so the width
//               parameters must stay at their package defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_inverse #(
  parameter int NUM_INPUT_BITS  = fir_pkg::SAMPLE_W,
  parameter int NUM_OUTPUT_BITS = fir_pkg::SUM_W,
  parameter int NUM_TAPS        = fir_pkg::NUM_TAPS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [NUM_OUTPUT_BITS-1:0] In,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [NUM_INPUT_BITS-1:0]  Out,
  input  logic                              clr_err,
  output logic                              range_err,
  output logic [15:0]                       sample_cnt
);

  import fir_pkg::*;

  localparam int c_DIFF_W = NUM_OUTPUT_BITS + 2;

  logic                              w_accept;
  logic                              w_oor;
  logic signed [c_DIFF_W-1:0]        w_diff;
  logic signed [NUM_INPUT_BITS-1:0]  w_fit;
  logic [NUM_INPUT_BITS-1:0]         w_tail;
  state_t                            w_state_nxt;

  logic signed [NUM_INPUT_BITS-1:0]  r_out;
  logic                              r_out_valid;
  logic signed [NUM_OUTPUT_BITS-1:0] r_y_prev;
  logic [15:0]                       r_sample_cnt;
  logic                              r_range_err;
  state_t                            r_state;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Sign-extend all three operands explicitly to the guarded width.
  assign w_diff = {{2{In[NUM_OUTPUT_BITS-1]}}, In}
                - {{2{r_y_prev[NUM_OUTPUT_BITS-1]}}, r_y_prev}
                + {{(c_DIFF_W-NUM_INPUT_BITS){w_tail[NUM_INPUT_BITS-1]}}, w_tail};

  assign w_oor = !sample_in_range(w_diff);
  assign w_fit = fit_sample(w_diff);

  // The fitted value (what is driven on Out) is what feeds the history.
  fir_inv_hist #(
    .DEPTH (NUM_TAPS),
    .WIDTH (NUM_INPUT_BITS)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (w_accept),
    .din      (w_fit),
    .tail     (w_tail)
  );

  // A new out-of-range accept takes priority over clr_err.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_oor ? ERR : RUN;
      RUN:     if (w_accept && w_oor) w_state_nxt = ERR;
      ERR:     if (clr_err && !(w_accept && w_oor)) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_y_prev     <= '0;
      r_sample_cnt <= '0;
      r_range_err  <= 1'b0;
      r_state      <= IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_out        <= w_fit;
        r_out_valid  <= 1'b1;
        r_y_prev     <= In;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
      if (w_accept && w_oor) begin
        r_range_err <= 1'b1;
      end else if (clr_err) begin
        r_range_err <= 1'b0;
      end
    end
  end

  assign Out        = r_out;
  assign out_valid  = r_out_valid;
  assign range_err  = r_range_err;
  assign sample_cnt = r_sample_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fir_inverse.sv
// ============================================================================
// Module      : tb_fir_inverse
// Description : Self-checking bench for fir_inverse. A behavioural model
//               tracks y/x history with plain integers and is compared
//               against the DUT on every negative edge; directed vectors
//               carry hand-computed literal expectations.
// Macro       : FIR_INV_SAT_EN - selects clamped vs wrapped expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_inverse;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [3:0]  out_data;
  logic               clr_err;
  logic               range_err;
  logic [15:0]        sample_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FIR_INV_SAT_EN
  localparam int c_EXP_P19 = 7;
  localparam int c_EXP_M20 = -8;
  localparam int c_EXP_M9  = -8;
`else
  localparam int c_EXP_P19 = 3;
  localparam int c_EXP_M20 = -4;
  localparam int c_EXP_M9  = 7;
`endif

  always #5 clk = ~clk;

  fir_inverse dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .In         (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Out        (out_data),
    .clr_err    (clr_err),
    .range_err  (range_err),
    .sample_cnt (sample_cnt)
  );

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int fit(input int d);
`ifdef FIR_INV_SAT_EN
    if (d > 7) return 7;
    if (d < -8) return -8;
    return d;
`else
    int w;
    w = d & 15;
    if (w > 7) w -= 16;
    return w;
`endif
  endfunction

  int m_x[5];        // m_x[0] newest recovered sample, m_x[4] from 5 accepts ago
  int m_yprev = 0;
  bit m_valid = 0;
  int m_out   = 0;
  bit m_err   = 0;
  int m_cnt   = 0;
  bit chk_en  = 0;

  always @(posedge clk) begin : model
    bit acc;
    int d;
    bit oor;
    if (!rst_n) begin
      foreach (m_x[i]) m_x[i] = 0;
      m_yprev = 0;
      m_valid = 0;
      m_out   = 0;
      m_err   = 0;
      m_cnt   = 0;
      chk_en  = 1;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        d   = int'(in_data) - m_yprev + m_x[4];
        oor = (d > 7) || (d < -8);
        for (int i = 4; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0]  = fit(d);
        m_out   = m_x[0];
        m_valid = 1;
        m_yprev = int'(in_data);
        m_cnt   = (m_cnt + 1) % 65536;
        if (oor) m_err = 1;
        else if (clr_err) m_err = 0;
      end else begin
        if (out_ready) m_valid = 0;
        if (clr_err) m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      if (m_valid) check("Out", $signed(out_data), m_out);
      check("range_err", range_err, m_err);
      check("sample_cnt", sample_cnt, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int y, input int exp_x, input string name);
    in_valid  = 1'b1;
    in_data   = 16'(y);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    check(name, $signed(out_data), exp_x);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n     = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_Out", $signed(out_data), 0);
    check("rst_range_err", range_err, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    rst_n = 1'b1;

    // Basic recovery, back-to-back
    push(1, 1, "basic_x0");
    push(3, 2, "basic_x1");
    push(6, 3, "basic_x2");
    push(2, -4, "basic_x3");
    push(9, 7, "basic_x4");
    push(0, -8, "basic_x5");
    check("basic_range_err", range_err, 0);
    check("basic_cnt", sample_cnt, 6);
    step();
    check("basic_drain_valid", out_valid, 0);

    // Backpressure
    do_reset();
    in_valid  = 1'b1;
    in_data   = 16'sd1;
    out_ready = 1'b0;
    step();
    in_data = 16'sd3;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_out", $signed(out_data), 1);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_resume_out", $signed(out_data), 2);
    check("bp_cnt", sample_cnt, 2);

    // Range error and clear
    do_reset();
    push(1, 1, "rng_x0");
    push(20, c_EXP_P19, "rng_x1");
    check("rng_err_set", range_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("rng_err_clr", range_err, 0);
    push(0, c_EXP_M20, "rng_x2");
    check("rng_err_set2", range_err, 1);

    // Clear colliding with a new out-of-range accept
    clr_err = 1'b1;
    push(-9, c_EXP_M9, "coll_x3");
    clr_err = 1'b0;
    check("coll_err_kept", range_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("coll_err_clr", range_err, 0);

    // Reset mid-stream
    do_reset();
    push(1, 1, "mid_x0");
    push(3, 2, "mid_x1");
    push(6, 3, "mid_x2");
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_cnt", sample_cnt, 0);
    rst_n = 1'b1;
    push(5, 5, "mid_post0");
    push(5, 0, "mid_post1");

    // Counter wrap
    do_reset();
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (65537) step();
    in_valid = 1'b0;
    check("wrap_cnt", sample_cnt, 1);
    check("wrap_out", $signed(out_data), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
